// File: rtl/hdmi_frame_gen_if.sv
// ---------------------------------------------------------------------------
// hdmi_frame_gen_if
// Video stream bundle produced by hdmi_frame_gen.
//   hdmi_v_sync     : frame start strobe (one clock per frame)
//   hdmi_h_sync     : line start strobe (one clock per line)
//   hdmi_data_valid : active pixels present on the lanes this clock
//   hdmi_data_y/cr/cb : N lanes of 8-bit signed samples, lane i = pixel x*N+i
// master = generator side, slave = sink side.
// ---------------------------------------------------------------------------
interface hdmi_frame_gen_if #(
  parameter int N = 2
);
  logic              hdmi_v_sync;
  logic              hdmi_h_sync;
  logic              hdmi_data_valid;
  logic [N-1:0][7:0] hdmi_data_y;
  logic [N-1:0][7:0] hdmi_data_cr;
  logic [N-1:0][7:0] hdmi_data_cb;

  modport master (
    output hdmi_v_sync, hdmi_h_sync, hdmi_data_valid,
    output hdmi_data_y, hdmi_data_cr, hdmi_data_cb
  );

  modport slave (
    input hdmi_v_sync, hdmi_h_sync, hdmi_data_valid,
    input hdmi_data_y, hdmi_data_cr, hdmi_data_cb
  );
endinterface

// File: rtl/hdmi_frame_gen.sv
// ---------------------------------------------------------------------------
// hdmi_frame_gen
// Test-pattern frame generator, N pixels per clock, YCrCb 8-bit signed.
// A line is H_BLANK blanking clocks followed by X_RES/N active clocks; a frame
// is V_BLANK blanking lines followed by Y_RES active lines. Frames run back to
// back while en=1; dropping en lets the current frame finish.
//
// Ports
//   clk, rst          : single clock, synchronous active-high reset
//   en                : run request, checked in IDLE and at the last frame clock
//   pat_sel           : 0 constant, 1 horizontal ramp, 2 vertical ramp, 3 checker
//   cfg_y/cr/cb       : constant-pattern colour
//   hdmi (master)     : registered video stream (see hdmi_frame_gen_if)
//   busy              : registered "state is RUN"
//   frame_cnt         : completed frames, wraps at 16 bits
// All stream outputs trail the internal counters by exactly one clock.
// ---------------------------------------------------------------------------
module hdmi_frame_gen #(
  parameter int N       = 2,
  parameter int X_RES   = 2160,
  parameter int Y_RES   = 1200,
  parameter int H_BLANK = 16,
  parameter int V_BLANK = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         pat_sel,
  input  logic signed [7:0]  cfg_y,
  input  logic signed [7:0]  cfg_cr,
  input  logic signed [7:0]  cfg_cb,
  hdmi_frame_gen_if.master   hdmi,
  output logic               busy,
  output logic [15:0]        frame_cnt
);

  localparam int H_TOTAL = H_BLANK + X_RES / N;
  localparam int V_TOTAL = V_BLANK + Y_RES;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hcnt;
  logic [VW-1:0]   vcnt;
  logic            h_last, v_last, frame_last, frame_start, active;

  // Pattern settings captured at frame start and held for the whole frame.
  logic [1:0]        pat_q;
  logic signed [7:0] cfg_y_q, cfg_cr_q, cfg_cb_q;

  logic [N-1:0][7:0] y_d, cr_d, cb_d;
  logic [7:0]        px, ln;

  assign h_last      = (hcnt == HW'(H_TOTAL - 1));
  assign v_last      = (vcnt == VW'(V_TOTAL - 1));
  assign frame_last  = (state_q == RUN) && h_last && v_last;
  assign frame_start = (state_q == RUN) && (hcnt == '0) && (vcnt == '0);
  assign active      = (state_q == RUN) && (vcnt >= VW'(V_BLANK)) &&
                       (hcnt >= HW'(H_BLANK));

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (frame_last && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------ counters
  // Counters sit at 0 in IDLE, so entering RUN always starts at frame top.
  always_ff @(posedge clk) begin
    if (rst || state_q != RUN) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // -------------------------------------------------- per-frame sampling
  // Capture happens during vertical blanking (V_BLANK >= 1), so the held
  // values are already stable before the first active pixel of the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q    <= '0;
      cfg_y_q  <= '0;
      cfg_cr_q <= '0;
      cfg_cb_q <= '0;
    end else if (frame_start) begin
      pat_q    <= pat_sel;
      cfg_y_q  <= cfg_y;
      cfg_cr_q <= cfg_cr;
      cfg_cb_q <= cfg_cb;
    end
  end

  // ------------------------------------------------------ pattern datapath
  // Only the low 8 bits of px/ln are ever used, and the low bits of a
  // product/difference depend only on the low bits of the operands, so the
  // coordinate math is done modulo 256.
  always_comb begin
    y_d  = '0;
    cr_d = '0;
    cb_d = '0;
    px   = '0;
    ln   = 8'(vcnt) - 8'(V_BLANK);
    for (int i = 0; i < N; i++) begin
      px = (8'(hcnt) - 8'(H_BLANK)) * 8'(N) + 8'(i);
      if (active) begin
        case (pat_q)
          2'd0: begin
            y_d[i]  = cfg_y_q;
            cr_d[i] = cfg_cr_q;
            cb_d[i] = cfg_cb_q;
          end
          2'd1:    y_d[i] = px;
          2'd2:    y_d[i] = ln;
          default: y_d[i] = (px[3] ^ ln[3]) ? 8'h64 : 8'h9C;  // +100 / -100
        endcase
      end
    end
  end

  // ----------------------------------------------------- output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hdmi.hdmi_v_sync     <= 1'b0;
      hdmi.hdmi_h_sync     <= 1'b0;
      hdmi.hdmi_data_valid <= 1'b0;
      hdmi.hdmi_data_y     <= '0;
      hdmi.hdmi_data_cr    <= '0;
      hdmi.hdmi_data_cb    <= '0;
      busy                 <= 1'b0;
      frame_cnt            <= '0;
    end else begin
      hdmi.hdmi_h_sync     <= (state_q == RUN) && (hcnt == '0);
      hdmi.hdmi_v_sync     <= frame_start;
      hdmi.hdmi_data_valid <= active;
      hdmi.hdmi_data_y     <= y_d;
      hdmi.hdmi_data_cr    <= cr_d;
      hdmi.hdmi_data_cb    <= cb_d;
      busy                 <= (state_q == RUN);
      if (frame_last) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hdmi_frame_gen.sv
// ---------------------------------------------------------------------------
// tb_hdmi_frame_gen
// Drives directed and randomized stimulus into hdmi_frame_gen and compares
// every output on every clock against a frame-position reference model.
// ---------------------------------------------------------------------------
module tb_hdmi_frame_gen;

  localparam int N  = 2;
  localparam int XR = 16;
  localparam int YR = 8;
  localparam int HB = 4;
  localparam int VB = 2;
  localparam int HT = HB + XR / N;  // 12
  localparam int VT = VB + YR;      // 10
  localparam int FR = HT * VT;      // 120

  logic              clk = 1'b0;
  logic              rst, en;
  logic [1:0]        pat_sel;
  logic signed [7:0] cfg_y, cfg_cr, cfg_cb;
  logic              busy;
  logic [15:0]       frame_cnt;

  hdmi_frame_gen_if #(.N(N)) hif ();

  hdmi_frame_gen #(
    .N(N), .X_RES(XR), .Y_RES(YR), .H_BLANK(HB), .V_BLANK(VB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pat_sel   (pat_sel),
    .cfg_y     (cfg_y),
    .cfg_cr    (cfg_cr),
    .cfg_cb    (cfg_cb),
    .hdmi      (hif.master),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------ reference model
  // State: running flag, position within the frame (0..FR-1) of the clock
  // about to be processed, the pattern captured at frame start, frame count.
  bit         m_run;
  int         m_pos;
  int         m_pat;
  logic [7:0] m_cy, m_cr, m_cb;
  int         m_fcnt;

  logic        e_vs, e_hs, e_dv, e_busy;
  logic [15:0] e_y, e_cr, e_cb, e_fcnt;

  task automatic model_step();
    int line, col, px, ln;
    logic [7:0] v;
    e_vs = 0; e_hs = 0; e_dv = 0; e_y = '0; e_cr = '0; e_cb = '0;
    if (rst) begin
      e_busy = 0;
      m_run  = 0; m_pos = 0; m_pat = 0; m_fcnt = 0;
      m_cy = '0; m_cr = '0; m_cb = '0;
    end else begin
      e_busy = m_run;
      if (m_run) begin
        line = m_pos / HT;
        col  = m_pos % HT;
        if (m_pos == 0) begin
          m_pat = int'(pat_sel);
          m_cy = cfg_y; m_cr = cfg_cr; m_cb = cfg_cb;
        end
        e_hs = (col == 0);
        e_vs = (m_pos == 0);
        e_dv = (line >= VB) && (col >= HB);
        if (e_dv) begin
          ln = line - VB;
          for (int i = 0; i < N; i++) begin
            px = (col - HB) * N + i;
            case (m_pat)
              0: begin
                e_y[i*8 +: 8] = m_cy; e_cr[i*8 +: 8] = m_cr; e_cb[i*8 +: 8] = m_cb;
              end
              1: e_y[i*8 +: 8] = 8'(px % 256);
              2: e_y[i*8 +: 8] = 8'(ln % 256);
              default: begin
                v = ((((px / 8) % 2) ^ ((ln / 8) % 2)) != 0) ? 8'd100 : 8'd156;
                e_y[i*8 +: 8] = v;
              end
            endcase
          end
        end
        if (m_pos == FR - 1) begin
          m_fcnt = (m_fcnt + 1) % 65536;
          m_pos  = 0;
          if (!en) m_run = 0;
        end else begin
          m_pos++;
        end
      end else if (en) begin
        m_run = 1;
        m_pos = 0;
      end
    end
    e_fcnt = 16'(m_fcnt);
  endtask

  // ------------------------------------------------ per-clock driver
  int cnt_vs, cnt_hs, cnt_dv, cyc;
  int vs_times[$];

  task automatic clear_counts();
    cnt_vs = 0; cnt_hs = 0; cnt_dv = 0;
    vs_times.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check("v_sync",     32'(hif.hdmi_v_sync),     32'(e_vs));
    check("h_sync",     32'(hif.hdmi_h_sync),     32'(e_hs));
    check("data_valid", 32'(hif.hdmi_data_valid), 32'(e_dv));
    check("busy",       32'(busy),                32'(e_busy));
    check("frame_cnt",  32'(frame_cnt),           32'(e_fcnt));
    check("data_y",     32'(hif.hdmi_data_y),     32'(e_y));
    check("data_cr",    32'(hif.hdmi_data_cr),    32'(e_cr));
    check("data_cb",    32'(hif.hdmi_data_cb),    32'(e_cb));
    if (hif.hdmi_v_sync) begin
      cnt_vs++;
      vs_times.push_back(cyc);
    end
    if (hif.hdmi_h_sync)     cnt_hs++;
    if (hif.hdmi_data_valid) cnt_dv++;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Advance until the model is about to process frame position pos.
  task automatic wait_pos(input int pos, input string tag);
    bit found = 0;
    for (int k = 0; k < 2 * FR + 2 && !found; k++) begin
      if (m_run && m_pos == pos) found = 1;
      else tick();
    end
    if (!found) check(tag, 32'd0, 32'd1);
  endtask

  // ------------------------------------------------ stimulus
  initial begin
    logic [15:0] f0;
    cyc = 0;
    rst = 1; en = 0; pat_sel = 0; cfg_y = 8'h11; cfg_cr = 8'h22; cfg_cb = 8'h33;
    m_run = 0; m_pos = 0; m_pat = 0; m_fcnt = 0;
    @(negedge clk);
    ticks(3);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_fcnt", 32'(frame_cnt), 32'd0);

    // Constant pattern, steady run: strobe counts and v_sync period.
    rst = 0; en = 1;
    tick();
    check("pre_vsync", 32'(hif.hdmi_v_sync), 32'd0);
    tick();
    check("first_vsync", 32'(hif.hdmi_v_sync), 32'd1);
    ticks(10);
    clear_counts();
    f0 = frame_cnt;
    ticks(2 * FR);
    check("win_vs", 32'(cnt_vs), 32'd2);
    check("win_hs", 32'(cnt_hs), 32'd20);
    check("win_dv", 32'(cnt_dv), 32'd128);
    if (vs_times.size() == 2) check("vs_period", 32'(vs_times[1] - vs_times[0]), 32'(FR));
    else                      check("vs_seen", 32'(vs_times.size()), 32'd2);
    check("fcnt_delta", 32'(frame_cnt - f0), 32'd2);

    // Horizontal ramp, vertical ramp, checker.
    for (int p = 1; p < 4; p++) begin
      pat_sel = 2'(p);
      ticks(2 * FR);
    end

    // en dropped at hcnt=5, vcnt=3: frame completes, then idle.
    pat_sel = 0;
    wait_pos(0, "wait_frame_top");
    clear_counts();
    f0 = frame_cnt;
    wait_pos(3 * HT + 5, "wait_drop_point");
    en = 0;
    ticks(2 * FR);
    check("drop_dv",   32'(cnt_dv), 32'd64);
    check("drop_vs",   32'(cnt_vs), 32'd1);
    check("drop_hs",   32'(cnt_hs), 32'd10);
    check("drop_busy", 32'(busy),   32'd0);
    check("drop_fcnt", 32'(frame_cnt - f0), 32'd1);

    // Reset mid-frame with en held high.
    en = 1; pat_sel = 2;
    ticks(50);
    rst = 1;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fcnt", 32'(frame_cnt), 32'd0);
    check("rst_dv",   32'(hif.hdmi_data_valid), 32'd0);
    rst = 0;
    tick();
    tick();
    check("rst_vsync", 32'(hif.hdmi_v_sync), 32'd1);

    // Pattern change mid-frame takes effect only at the next frame.
    pat_sel = 0; cfg_y = 8'h5A; cfg_cr = 8'hA5; cfg_cb = 8'h0F;
    ticks(FR);
    wait_pos(0, "wait_frame_top2");
    ticks(40);
    pat_sel = 1; cfg_y = 8'h00;
    ticks(2 * FR);

    // Randomized run.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(19, 0) == 0) pat_sel = 2'($urandom);
      if ($urandom_range(19, 0) == 0) begin
        cfg_y = 8'($urandom); cfg_cr = 8'($urandom); cfg_cb = 8'($urandom);
      end
      if ($urandom_range(149, 0) == 0) en = ~en;
      if (!en && $urandom_range(39, 0) == 0) en = 1;
      rst = ($urandom_range(399, 0) == 0);
      tick();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
